// File: rtl/avr_debug_pkg.sv
// Shared definitions for the debug register-access initiator:
// host opcodes and FSM state encoding.
package avr_debug_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_RESP,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/avr_debug_halt_ctrl.sv
// CPU halt handshake: drives the halt request, counts cycles waiting for the
// core to halt, and flags loss of halt while the register port is in use.
module avr_debug_halt_ctrl
    import avr_debug_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_en,
    input  logic wait_en,
    input  logic own_en,
    input  logic cpu_halted,
    output logic cpu_halt_req,
    output logic halt_ok,
    output logic timeout,
    output logic halt_lost
);

    logic [15:0] wait_cnt;

    // Counter only runs while waiting; anything else returns it to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (wait_en && !cpu_halted) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign cpu_halt_req = req_en;
    assign halt_ok      = wait_en && cpu_halted;
    assign timeout      = wait_en && !cpu_halted && (wait_cnt == 16'(HALT_TIMEOUT - 1));
    assign halt_lost    = own_en && !cpu_halted;

endmodule

// File: rtl/avr_debug_reg_access.sv
// Debug-side initiator for the general-purpose register bank: halts the core,
// performs READ / WRITE / DUMP through the bank port and returns responses.
module avr_debug_reg_access
    import avr_debug_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255,
    parameter int NUM_REGS     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       rsp_last,
    output logic       cpu_halt_req,
    input  logic       cpu_halted,
    output logic [4:0] rf_addr,
    output logic       rf_write,
    output logic [7:0] rf_wdata,
    input  logic [7:0] rf_rdata
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t     state, state_next;
    logic [1:0] op_q, op_next;
    logic [4:0] idx_q, idx_next;
    logic [7:0] wdata_q, wdata_next;
    logic [7:0] data_q, data_next;
    logic       err_q, err_next;
    logic       last_q, last_next;
    logic       halt_cmd_q, halt_cmd_next;
    logic       ready_q;
    logic       req_en, wait_en, own_en;
    logic       halt_ok, timeout, halt_lost;

    assign wait_en = (state == ST_HALT_WAIT);
    assign own_en  = (state == ST_RD_ADDR) || (state == ST_RD_DATA) || (state == ST_WR);
    assign req_en  = wait_en || own_en || ((state == ST_RESP) && halt_cmd_q);

    avr_debug_halt_ctrl #(
        .HALT_TIMEOUT(HALT_TIMEOUT)
    ) u_halt_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_en       (req_en),
        .wait_en      (wait_en),
        .own_en       (own_en),
        .cpu_halted   (cpu_halted),
        .cpu_halt_req (cpu_halt_req),
        .halt_ok      (halt_ok),
        .timeout      (timeout),
        .halt_lost    (halt_lost)
    );

    always_comb begin
        state_next    = state;
        op_next       = op_q;
        idx_next      = idx_q;
        wdata_next    = wdata_q;
        data_next     = data_q;
        err_next      = err_q;
        last_next     = last_q;
        halt_cmd_next = halt_cmd_q;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_next       = cmd_op;
                    wdata_next    = cmd_wdata;
                    idx_next      = (cmd_op == OP_DUMP) ? 5'd0 : cmd_addr;
                    data_next     = '0;
                    err_next      = (cmd_op == OP_RSVD);
                    last_next     = (cmd_op == OP_RSVD);
                    halt_cmd_next = (cmd_op != OP_RSVD);
                    state_next    = (cmd_op == OP_RSVD) ? ST_RESP : ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (halt_ok) begin
                    state_next = (op_q == OP_WRITE) ? ST_WR : ST_RD_ADDR;
                end else if (timeout) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    last_next  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            // Losing the halt while the port is ours ends the command with an error.
            ST_RD_ADDR, ST_RD_DATA, ST_WR: begin
                if (halt_lost) begin
                    data_next = '0;
                    err_next  = 1'b1;
                    last_next = 1'b1;
                end else if (state == ST_RD_DATA) begin
                    data_next = rf_rdata;
                    err_next  = 1'b0;
                    last_next = (op_q != OP_DUMP) || (idx_q == LAST_IDX);
                end else if (state == ST_WR) begin
                    data_next = wdata_q;
                    err_next  = 1'b0;
                    last_next = 1'b1;
                end
                if (halt_lost || state != ST_RD_ADDR) begin
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!last_q) begin
                        idx_next   = idx_q + 5'd1;
                        state_next = ST_RD_ADDR;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low through the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_READ;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            halt_cmd_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_next;
            op_q       <= op_next;
            idx_q      <= idx_next;
            wdata_q    <= wdata_next;
            data_q     <= data_next;
            err_q      <= err_next;
            last_q     <= last_next;
            halt_cmd_q <= halt_cmd_next;
            ready_q    <= (state_next == ST_IDLE);
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_addr  = idx_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_last  = last_q;
    assign rf_addr   = idx_q;
    assign rf_wdata  = wdata_q;
    assign rf_write  = (state == ST_WR) && cpu_halted;

endmodule

// File: tb/tb_avr_debug_reg_access.sv
// Directed self-checking bench for avr_debug_reg_access with a registered
// register-bank model and a hand-driven cpu_halted line.
module tb_avr_debug_reg_access;
    import avr_debug_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_last;
    logic       cpu_halt_req;
    logic       cpu_halted;
    logic [4:0] rf_addr;
    logic       rf_write;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;

    logic [7:0] regs [32];
    int         write_count;
    logic [4:0] wr_addr_seen;
    logic [7:0] wr_data_seen;
    int         compare_count;
    int         fail_count;

    avr_debug_reg_access #(
        .HALT_TIMEOUT(10),
        .NUM_REGS    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_last     (rsp_last),
        .cpu_halt_req (cpu_halt_req),
        .cpu_halted   (cpu_halted),
        .rf_addr      (rf_addr),
        .rf_write     (rf_write),
        .rf_wdata     (rf_wdata),
        .rf_rdata     (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank read port: data appears one cycle after the address.
    always @(posedge clk) rf_rdata <= regs[rf_addr];

    always @(negedge clk) begin
        if (rf_write) begin
            write_count++;
            wr_addr_seen = rf_addr;
            wr_data_seen = rf_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wd);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitValid(input string tag, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, rsp_valid, 1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int  n;
        int  wc0;
        logic go;
        compare_count = 0;
        fail_count    = 0;
        write_count   = 0;
        wr_addr_seen  = '0;
        wr_data_seen  = '0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = OP_READ;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b0;
        cpu_halted = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 8'(i);

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_halt_req", cpu_halt_req, 0);
        checkOutput("rst_rf_write", rf_write, 0);
        checkOutput("rst_rf_addr", rf_addr, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);

        // Reserved opcode: immediate error, no halt
        applyStimulus(OP_RSVD, 5'd4, 8'h00);
        checkOutput("rsvd_valid", rsp_valid, 1);
        checkOutput("rsvd_err", rsp_err, 1);
        checkOutput("rsvd_last", rsp_last, 1);
        checkOutput("rsvd_halt_req", cpu_halt_req, 0);
        handshake();
        repeat (2) @(negedge clk);

        // WRITE addr 5 = 0xA7, halt acknowledged 3 cycles late
        wc0 = write_count;
        applyStimulus(OP_WRITE, 5'd5, 8'hA7);
        checkOutput("wr_halt_req", cpu_halt_req, 1);
        repeat (3) @(negedge clk);
        cpu_halted = 1'b1;
        waitValid("wr_valid", n);
        checkOutput("wr_pulses", write_count - wc0, 1);
        checkOutput("wr_rf_addr", wr_addr_seen, 5);
        checkOutput("wr_rf_wdata", wr_data_seen, 8'hA7);
        checkOutput("wr_rsp_addr", rsp_addr, 5);
        checkOutput("wr_rsp_data", rsp_data, 8'hA7);
        checkOutput("wr_rsp_err", rsp_err, 0);
        checkOutput("wr_rsp_last", rsp_last, 1);
        checkOutput("wr_halt_held", cpu_halt_req, 1);
        handshake();
        checkOutput("wr_rsp_drop", rsp_valid, 0);
        checkOutput("wr_halt_release", cpu_halt_req, 0);
        cpu_halted = 1'b0;
        @(negedge clk);
        checkOutput("wr_idle_ready", cmd_ready, 1);

        // READ addr 30, two-cycle latency from RD_ADDR
        regs[30] = 8'h3C;
        wc0 = write_count;
        applyStimulus(OP_READ, 5'd30, 8'h00);
        cpu_halted = 1'b1;
        @(negedge clk);
        checkOutput("rd_addr_cycle_valid", rsp_valid, 0);
        checkOutput("rd_addr_cycle_rf_addr", rf_addr, 30);
        @(negedge clk);
        checkOutput("rd_data_cycle_valid", rsp_valid, 0);
        checkOutput("rd_data_cycle_rf_addr", rf_addr, 30);
        @(negedge clk);
        checkOutput("rd_valid_latency", rsp_valid, 1);
        checkOutput("rd_rsp_data", rsp_data, 8'h3C);
        checkOutput("rd_rsp_addr", rsp_addr, 30);
        checkOutput("rd_rsp_err", rsp_err, 0);
        checkOutput("rd_rsp_last", rsp_last, 1);
        handshake();
        checkOutput("rd_no_write", write_count - wc0, 0);
        cpu_halted = 1'b0;
        @(negedge clk);

        // DUMP with random back-pressure
        for (int i = 0; i < 32; i++) regs[i] = 8'(i) ^ 8'h55;
        wc0 = write_count;
        applyStimulus(OP_DUMP, 5'd17, 8'h00);
        cpu_halted = 1'b1;
        for (int i = 0; i < 32; i++) begin
            waitValid("dump_valid", n);
            for (int k = 0; k < 12; k++) begin
                checkOutput("dump_addr", rsp_addr, i);
                checkOutput("dump_data", rsp_data, (i ^ 32'h55));
                checkOutput("dump_last", rsp_last, (i == 31) ? 1 : 0);
                checkOutput("dump_err", rsp_err, 0);
                go = (k >= 8) || ($urandom_range(0, 1) == 1);
                rsp_ready = go;
                @(negedge clk);
                if (go) break;
            end
            rsp_ready = 1'b0;
        end
        checkOutput("dump_halt_release", cpu_halt_req, 0);
        checkOutput("dump_no_write", write_count - wc0, 0);
        cpu_halted = 1'b0;
        @(negedge clk);

        // Halt timeout with HALT_TIMEOUT = 10
        wc0 = write_count;
        applyStimulus(OP_READ, 5'd3, 8'h00);
        waitValid("to_valid", n);
        checkOutput("to_cycles", n, 10);
        checkOutput("to_err", rsp_err, 1);
        checkOutput("to_last", rsp_last, 1);
        checkOutput("to_data", rsp_data, 0);
        checkOutput("to_halt_held", cpu_halt_req, 1);
        handshake();
        checkOutput("to_halt_release", cpu_halt_req, 0);
        checkOutput("to_no_write", write_count - wc0, 0);
        @(negedge clk);

        // Halt lost during DUMP at index 12
        applyStimulus(OP_DUMP, 5'd0, 8'h00);
        cpu_halted = 1'b1;
        for (int i = 0; i < 12; i++) begin
            waitValid("hl_valid", n);
            checkOutput("hl_addr", rsp_addr, i);
            handshake();
        end
        cpu_halted = 1'b0;
        waitValid("hl_err_valid", n);
        checkOutput("hl_err_addr", rsp_addr, 12);
        checkOutput("hl_err", rsp_err, 1);
        checkOutput("hl_last", rsp_last, 1);
        handshake();
        checkOutput("hl_halt_release", cpu_halt_req, 0);
        @(negedge clk);
        checkOutput("hl_idle_ready", cmd_ready, 1);
        checkOutput("hl_no_more_reads", rf_addr, 12);

        // Reset while index 7 of a DUMP is pending
        applyStimulus(OP_DUMP, 5'd0, 8'h00);
        cpu_halted = 1'b1;
        for (int i = 0; i < 7; i++) begin
            waitValid("rs_valid", n);
            handshake();
        end
        waitValid("rs_valid7", n);
        checkOutput("rs_addr7", rsp_addr, 7);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rs_rsp_drop", rsp_valid, 0);
        checkOutput("rs_halt_drop", cpu_halt_req, 0);
        checkOutput("rs_ready_low", cmd_ready, 0);
        cpu_halted = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rs_ready_back", cmd_ready, 1);
        checkOutput("rs_rsp_data", rsp_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
